// File: rtl/flow_token_shaper_if.sv
// ----------------------------------------------------------------------------
// flow_token_shaper_if
//   Send-request handshake between the token shaper and the packet builder.
//   The shaper offers one {flow, size} request at a time. The builder takes it
//   on a cycle where both req_valid and req_ready are high.
//
//   Signals
//     req_valid  shaper -> builder  request valid
//     req_flow   shaper -> builder  requesting flow index (FLOW_W)
//     req_size   shaper -> builder  bytes to send (SIZE_W)
//     req_ready  builder -> shaper  builder accepts the request
//
//   Modports
//     master  the shaper side (drives valid/flow/size, samples ready)
//     slave   the builder side
// ----------------------------------------------------------------------------
interface flow_token_shaper_if #(
    parameter int FLOW_W = 4,
    parameter int SIZE_W = 16
) ();
    logic              req_valid;
    logic [FLOW_W-1:0] req_flow;
    logic [SIZE_W-1:0] req_size;
    logic              req_ready;

    modport master (
        output req_valid,
        output req_flow,
        output req_size,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_flow,
        input  req_size,
        output req_ready
    );
endinterface

// File: rtl/flow_token_shaper.sv
// ----------------------------------------------------------------------------
// flow_token_shaper
//   Multi-flow token-bucket rate shaper. Each flow has a packet size, a refill
//   amount per period and an enable bit. A free-running period counter
//   produces a refill pulse every UPDATE_PERIOD cycles. On that pulse every
//   enabled flow's bucket grows by its token amount, capped at
//   token << BURST_SHIFT. A flow is eligible when it is enabled, has a
//   non-zero size and holds at least one packet's worth of bytes. A
//   round-robin arbiter offers one eligible flow at a time to the packet
//   builder and debits the bucket when the builder accepts.
//
//   Ports
//     clk_i               system clock
//     rst_i               synchronous, active-high reset
//     wr_size_addr_i      size table write address
//     wr_size_data_i      packet size in bytes (CRC included)
//     wr_size_wr_en_i     size table write strobe
//     wr_token_addr_i     token table write address
//     wr_token_data_i     bytes added to the bucket per period
//     wr_token_wr_en_i    token table write strobe
//     wr_flow_en_addr_i   enable table write address
//     wr_flow_en_data_i   flow enable (writing 0 also empties the bucket)
//     wr_flow_en_wr_en_i  enable table write strobe
//     req_o               send-request handshake (master side)
//     refill_pulse_o      one-cycle pulse marking each refill
// ----------------------------------------------------------------------------
module flow_token_shaper #(
    parameter int FLOW_CNT      = 16,
    parameter int SIZE_W        = 16,
    parameter int TOKEN_W       = 32,
    parameter int UPDATE_PERIOD = 100,
    parameter int BURST_SHIFT   = 2,
    localparam int FLOW_W       = (FLOW_CNT == 1) ? 1 : $clog2(FLOW_CNT),
    localparam int BKT_W        = TOKEN_W + BURST_SHIFT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic [FLOW_W-1:0]     wr_size_addr_i,
    input  logic [SIZE_W-1:0]     wr_size_data_i,
    input  logic                  wr_size_wr_en_i,

    input  logic [FLOW_W-1:0]     wr_token_addr_i,
    input  logic [TOKEN_W-1:0]    wr_token_data_i,
    input  logic                  wr_token_wr_en_i,

    input  logic [FLOW_W-1:0]     wr_flow_en_addr_i,
    input  logic                  wr_flow_en_data_i,
    input  logic                  wr_flow_en_wr_en_i,

    flow_token_shaper_if.master   req_o,

    output logic                  refill_pulse_o
);

    // Arithmetic width wide enough for bucket + token and for the packet size,
    // plus one bit so the sum never wraps before saturation.
    localparam int ACC_W = ((BKT_W > SIZE_W) ? BKT_W : SIZE_W) + 1;
    localparam int CNT_W = $clog2(UPDATE_PERIOD);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(UPDATE_PERIOD - 1);
    localparam logic [FLOW_W-1:0] FLOW_LAST = FLOW_W'(FLOW_CNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFFER,
        ST_GAP
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SIZE_W-1:0]  size_tbl_q  [FLOW_CNT];
    logic [TOKEN_W-1:0] token_tbl_q [FLOW_CNT];
    logic [FLOW_CNT-1:0] en_q;
    logic [BKT_W-1:0]   bkt_q [FLOW_CNT];
    logic [BKT_W-1:0]   bkt_d [FLOW_CNT];

    logic [CNT_W-1:0]   cnt_q;
    logic               refill_pulse_q;

    state_e             state_q,     state_d;
    logic               req_valid_q, req_valid_d;
    logic [FLOW_W-1:0]  req_flow_q,  req_flow_d;
    logic [SIZE_W-1:0]  req_size_q,  req_size_d;
    logic [FLOW_W-1:0]  rr_ptr_q,    rr_ptr_d;

    logic               fire;
    logic [FLOW_CNT-1:0] elig;
    logic               pick_found;
    logic [FLOW_W-1:0]  pick_flow;
    logic [SIZE_W-1:0]  pick_size;

    // ------------------------------------------------------------------
    // Bucket update: optional refill, optional debit, floor at 0. The cap
    // only applies when a refill happens, so a debit alone never shrinks a
    // bucket below what it held minus the packet size.
    // ------------------------------------------------------------------
    function automatic logic [BKT_W-1:0] bkt_next(
        input logic [BKT_W-1:0]   bkt,
        input logic [TOKEN_W-1:0] tok,
        input logic               refill,
        input logic [SIZE_W-1:0]  debit
    );
        logic [ACC_W-1:0] acc;
        logic [ACC_W-1:0] dbt;
        logic [ACC_W-1:0] cap;
        acc = ACC_W'(bkt) + (refill ? ACC_W'(tok) : '0);
        dbt = ACC_W'(debit);
        acc = (acc >= dbt) ? (acc - dbt) : '0;
        cap = ACC_W'(tok) << BURST_SHIFT;
        if (refill && (acc > cap)) begin
            acc = cap;
        end
        return BKT_W'(acc);
    endfunction

    // ------------------------------------------------------------------
    // Configuration tables. Addresses beyond the last flow match no entry
    // and are therefore dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int f = 0; f < FLOW_CNT; f++) begin
                size_tbl_q[f]  <= '0;
                token_tbl_q[f] <= '0;
            end
            en_q <= '0;
        end else begin
            for (int f = 0; f < FLOW_CNT; f++) begin
                if (wr_size_wr_en_i && (wr_size_addr_i == FLOW_W'(f))) begin
                    size_tbl_q[f] <= wr_size_data_i;
                end
                if (wr_token_wr_en_i && (wr_token_addr_i == FLOW_W'(f))) begin
                    token_tbl_q[f] <= wr_token_data_i;
                end
                if (wr_flow_en_wr_en_i && (wr_flow_en_addr_i == FLOW_W'(f))) begin
                    en_q[f] <= wr_flow_en_data_i;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Period counter and registered refill pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q          <= '0;
            refill_pulse_q <= 1'b0;
        end else begin
            refill_pulse_q <= (cnt_q == CNT_LAST);
            cnt_q          <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Bucket next state. A disable write empties the bucket and overrides
    // any refill or debit landing on the same edge.
    // ------------------------------------------------------------------
    always_comb begin
        for (int f = 0; f < FLOW_CNT; f++) begin
            bkt_d[f] = bkt_q[f];
            if (wr_flow_en_wr_en_i && !wr_flow_en_data_i &&
                (wr_flow_en_addr_i == FLOW_W'(f))) begin
                bkt_d[f] = '0;
            end else begin
                bkt_d[f] = bkt_next(bkt_q[f], token_tbl_q[f],
                                    refill_pulse_q && en_q[f],
                                    (fire && (req_flow_q == FLOW_W'(f))) ? req_size_q : '0);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int f = 0; f < FLOW_CNT; f++) begin
                bkt_q[f] <= '0;
            end
        end else begin
            for (int f = 0; f < FLOW_CNT; f++) begin
                bkt_q[f] <= bkt_d[f];
            end
        end
    end

    // ------------------------------------------------------------------
    // Eligibility and round-robin pick, scanning upward from rr_ptr_q
    // ------------------------------------------------------------------
    always_comb begin
        for (int f = 0; f < FLOW_CNT; f++) begin
            elig[f] = en_q[f] && (size_tbl_q[f] != '0) &&
                      (ACC_W'(bkt_q[f]) >= ACC_W'(size_tbl_q[f]));
        end
    end

    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_flow  = '0;
        pick_size  = '0;
        for (int i = 0; i < FLOW_CNT; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= FLOW_CNT) begin
                idx = idx - FLOW_CNT;
            end
            if (!pick_found && elig[FLOW_W'(idx)]) begin
                pick_found = 1'b1;
                pick_flow  = FLOW_W'(idx);
                pick_size  = size_tbl_q[FLOW_W'(idx)];
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbiter FSM. The captured flow/size stay frozen through OFFER, so a
    // table rewrite or disable never disturbs an outstanding request. GAP
    // gives the debited bucket one cycle to settle before the next pick.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_flow_d  = req_flow_q;
        req_size_d  = req_size_q;
        rr_ptr_d    = rr_ptr_q;
        fire        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    req_flow_d  = pick_flow;
                    req_size_d  = pick_size;
                    req_valid_d = 1'b1;
                    state_d     = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (req_o.req_ready) begin
                    fire        = 1'b1;
                    req_valid_d = 1'b0;
                    rr_ptr_d    = (req_flow_q == FLOW_LAST) ? '0 : req_flow_q + 1'b1;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                req_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            req_valid_q <= 1'b0;
            req_flow_q  <= '0;
            req_size_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_flow_q  <= req_flow_d;
            req_size_q  <= req_size_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign req_o.req_valid = req_valid_q;
    assign req_o.req_flow  = req_flow_q;
    assign req_o.req_size  = req_size_q;
    assign refill_pulse_o  = refill_pulse_q;

endmodule
